conv2d_stream: RTL and testbench
================================

# conv2d_stream

Streaming 2-D convolution engine for raster pixel data. It is the parametrised successor of the fixed 3x3 Laplacian edge-detect stage. Pixels arrive one per accepted beat. The block keeps (KERNEL_DIM-1) full rows plus KERNEL_DIM pixels of line buffer, convolves each fully-interior window with a runtime-loadable signed kernel, then shifts and clamps the result to pixel range. It sits between the pixel source (camera/frame reader) and downstream CNN stages, and adds input stalls, frame restart, a rescale shift and an absolute-value mode.

## Interface
- WORD_SIZE, 8, pixel width (unsigned)
- ROW_SIZE, 540, pixels per image row; must be ≥ KERNEL_DIM
- KERNEL_DIM, 3, kernel edge; odd, 3..7
- COEF_WIDTH, 8, signed coefficient width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_pixel is accepted this cycle
- in_sof  in  1  qualified by in_valid; this pixel is row 0, col 0 of a new frame
- in_pixel  in  WORD_SIZE  input pixel, raster order
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(KERNEL_DIM*KERNEL_DIM)  row-major index r*KERNEL_DIM+c
- coef_data  in  COEF_WIDTH  signed coefficient
- shift  in  4  arithmetic right-shift applied to the sum before clamping
- abs_en  in  1  take the absolute value of the shifted sum before clamping
- out_valid  out  1  out_pixel holds a convolution result
- out_pixel  out  WORD_SIZE  clamped result

## Operation
- Window: r=0 is the oldest row and c=0 is the oldest column. The result is the correlation sum over r,c of win[r][c]*coef[r][c], with no kernel flip.
- Line buffer and counters advance only on in_valid. col wraps from ROW_SIZE-1 to 0 and increments row; row saturates at KERNEL_DIM-1.
- A beat produces a result iff row ≥ KERNEL_DIM-1 and col ≥ KERNEL_DIM-1, where row and col are the coordinates of the incoming pixel. Output per frame is (H-K+1) x (ROW_SIZE-K+1), raster order. No results are produced on edge columns or during the fill rows.
- in_sof with in_valid: counters are forced so this pixel is (0,0). Stale buffer contents are never used, because results are only produced once a full new window exists. Results already in the pipeline still complete.
- Coefficients: registered array. The reset value is the generalised Laplacian: centre K*K-1, all others -1. A write takes effect for windows sampled on the following cycle. A write concurrent with in_valid is legal; that beat uses the old value.
- Arithmetic:
  - products are WORD_SIZE+COEF_WIDTH+1 bits, signed
  - the sum adds $clog2(K*K) guard bits, so no overflow is possible
  - the sum goes through an arithmetic shift right by shift
  - if abs_en, the absolute value is taken
  - the result is clamped to [0, 2^WORD_SIZE-1]
- shift and abs_en are sampled in the clamp stage. They are quasi-static; a change mid-frame applies from the next result.

## Timing
- Pipeline: S0 accept/window sample → S1 product registers → S2 adder-tree register → S3 shift/abs/clamp output register.
- Latency: 3 cycles from the accepting edge to the out_valid edge, fixed regardless of stalls.
- No output backpressure. out_valid is a 1-cycle pulse per result; gaps mirror input gaps.
- Reset values: out_valid=0, out_pixel=0, row=col=0, pipeline valid bits 0, coefficients at Laplacian default. Buffer contents are don't-care.
- Reset mid-frame: in-flight results are dropped; the first valid output appears only after a full refill.
- Throughput: 1 result/cycle at in_valid=1 continuously.

## Structure
- Package conv_pkg holds the following:
  - coefficient and sum width localparam functions
  - the default-kernel function (K → Laplacian array)
  - the window typedef
- Sub-module conv_line_buffer (clk, rst, in_valid, in_sof, in_pixel → window, window_valid) owns the shift buffer and row/col counters.
- The top level owns the coefficient registers, the multiply/add pipeline and the clamp.

## Test plan
- ROW_SIZE=8, K=3, default kernel, 8x8 frame of constant 10 → exactly 36 out_valid pulses, all out_pixel=0, first pulse 3 cycles after pixel (2,2) is accepted.
- Single pixel 100 at (3,3), rest 0, default kernel → the result centred on it is 255 (800 clamped). Its 8 neighbour results are 0; with abs_en=1 they are 100.
- Load identity (centre 1, others 0) via coef_we → out_pixel equals the input pixel at (r-1,c-1). Ramp image 0..63 gives outputs 9,10,…,14,17,….
- Box kernel (all 1), shift=3, constant 80 → 720>>3 = 90 on every output.
- Same ramp with in_valid toggled in a random ~50% pattern → the identical result sequence and 36 pulses, each 3 cycles after its accepting beat.
- Assert rst after row 4, then restart the frame with in_sof → no out_valid until (2,2) of the new frame, and coefficients are back to the Laplacian default.

Source files
------------

// File: rtl/conv2d_stream_pkg.sv
// Shared sizing helpers and the default kernel for the streaming convolution engine.
package conv_pkg;

   localparam int unsigned MaxKernelDim = 7;

   // One window is KERNEL_DIM*KERNEL_DIM pixels, flattened row-major (r*K+c).
   // Bounded by the largest supported kernel so it can be shared across configurations.
   typedef logic [MaxKernelDim*MaxKernelDim-1:0][31:0] window_t;

   function automatic int prod_width(input int word_size, input int coef_width);
      return word_size + coef_width + 1;
   endfunction

   function automatic int sum_width(input int word_size, input int coef_width, input int k);
      return word_size + coef_width + 1 + $clog2(k * k);
   endfunction

   // Generalised Laplacian: centre K*K-1, all other taps -1.
   function automatic int default_coef(input int k, input int idx);
      return (idx == (k * k) / 2) ? (k * k - 1) : -1;
   endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Pixel stream, coefficient load and output bus of conv2d_stream.
interface conv2d_stream_if #(
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned KERNEL_DIM = 3,
   parameter int unsigned COEF_WIDTH = 8
);
   localparam int unsigned AddrW = $clog2(KERNEL_DIM * KERNEL_DIM);

   logic                  in_valid;
   logic                  in_sof;
   logic [WORD_SIZE-1:0]  in_pixel;
   logic                  coef_we;
   logic [AddrW-1:0]      coef_addr;
   logic [COEF_WIDTH-1:0] coef_data;
   logic [3:0]            shift;
   logic                  abs_en;
   logic                  out_valid;
   logic [WORD_SIZE-1:0]  out_pixel;

   modport master (
      output in_valid, in_sof, in_pixel, coef_we, coef_addr, coef_data, shift, abs_en,
      input  out_valid, out_pixel
   );

   modport slave (
      input  in_valid, in_sof, in_pixel, coef_we, coef_addr, coef_data, shift, abs_en,
      output out_valid, out_pixel
   );
endinterface

// File: rtl/conv2d_stream_line_buffer.sv
// Raster line buffer: keeps (K-1) rows plus K pixels and emits a registered KxK window.
module conv_line_buffer #(
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned ROW_SIZE   = 540,
   parameter int unsigned KERNEL_DIM = 3
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_valid,
   input  logic                                        in_sof,
   input  logic [WORD_SIZE-1:0]                        in_pixel,
   output logic [KERNEL_DIM*KERNEL_DIM*WORD_SIZE-1:0] window,
   output logic                                        window_valid
);
   localparam int unsigned Depth = (KERNEL_DIM - 1) * ROW_SIZE + KERNEL_DIM;
   localparam int unsigned ColW  = $clog2(ROW_SIZE);
   localparam int unsigned RowW  = $clog2(KERNEL_DIM);

   logic [WORD_SIZE-1:0] sr_q [Depth-1];
   logic [WORD_SIZE-1:0] taps [Depth];
   logic [ColW-1:0]      col_q, cur_col;
   logic [RowW-1:0]      row_q, cur_row;
   logic [KERNEL_DIM*KERNEL_DIM*WORD_SIZE-1:0] window_d;

   // taps[d] is the pixel d beats older than the incoming one (taps[0] = incoming).
   assign taps[0] = in_pixel;
   for (genvar i = 1; i < Depth; i++) begin : g_tap
      assign taps[i] = sr_q[i-1];
   end

   always_comb begin
      cur_col  = in_sof ? '0 : col_q;
      cur_row  = in_sof ? '0 : row_q;
      window_d = '0;
      for (int r = 0; r < KERNEL_DIM; r++) begin
         for (int c = 0; c < KERNEL_DIM; c++) begin
            window_d[(r*KERNEL_DIM+c)*WORD_SIZE +: WORD_SIZE] =
               taps[(KERNEL_DIM-1-r)*ROW_SIZE + (KERNEL_DIM-1-c)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         sr_q[0] <= in_pixel;
         for (int i = 1; i < Depth - 1; i++) sr_q[i] <= sr_q[i-1];
         window <= window_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         window_valid <= 1'b0;
      end else begin
         window_valid <= in_valid && (cur_row == RowW'(KERNEL_DIM - 1)) &&
                         (cur_col >= ColW'(KERNEL_DIM - 1));
         if (in_valid) begin
            if (cur_col == ColW'(ROW_SIZE - 1)) begin
               col_q <= '0;
               row_q <= (cur_row == RowW'(KERNEL_DIM - 1)) ? cur_row : cur_row + 1'b1;
            end else begin
               col_q <= cur_col + 1'b1;
               row_q <= cur_row;
            end
         end
      end
   end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution: line buffer, product/adder-tree pipeline, shift/abs/clamp output.
module conv2d_stream
   import conv_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned ROW_SIZE   = 540,
   parameter int unsigned KERNEL_DIM = 3,
   parameter int unsigned COEF_WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   conv2d_stream_if.slave  bus
);
   localparam int unsigned Taps  = KERNEL_DIM * KERNEL_DIM;
   localparam int unsigned AddrW = $clog2(Taps);
   localparam int unsigned ProdW = prod_width(WORD_SIZE, COEF_WIDTH);
   localparam int unsigned SumW  = sum_width(WORD_SIZE, COEF_WIDTH, KERNEL_DIM);

   logic [Taps*WORD_SIZE-1:0]    window;
   logic                         window_valid;
   logic signed [COEF_WIDTH-1:0] coef_q [Taps];
   logic signed [COEF_WIDTH-1:0] coef_s1 [Taps];
   logic signed [ProdW-1:0]      prod_q [Taps];
   logic signed [SumW-1:0]       sum_d, sum_q, shifted, mag;
   logic [WORD_SIZE-1:0]         clamped, out_pixel_q;
   logic                         v1_q, v2_q, out_valid_q;

   conv_line_buffer #(
      .WORD_SIZE  (WORD_SIZE),
      .ROW_SIZE   (ROW_SIZE),
      .KERNEL_DIM (KERNEL_DIM)
   ) u_line_buffer (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (bus.in_valid),
      .in_sof       (bus.in_sof),
      .in_pixel     (bus.in_pixel),
      .window       (window),
      .window_valid (window_valid)
   );

   // coef_s1 snapshots the kernel alongside the window, so a write landing on the
   // same edge as a beat does not reach that beat's products.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < Taps; i++) begin
            coef_q[i]  <= COEF_WIDTH'(default_coef(KERNEL_DIM, i));
            coef_s1[i] <= COEF_WIDTH'(default_coef(KERNEL_DIM, i));
         end
      end else begin
         if (bus.coef_we && (bus.coef_addr < AddrW'(Taps))) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
         end
         coef_s1 <= coef_q;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < Taps; i++) begin
         prod_q[i] <= ProdW'($signed({1'b0, window[i*WORD_SIZE +: WORD_SIZE]})) *
                      ProdW'(coef_s1[i]);
      end
      sum_q <= sum_d;
   end

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < Taps; i++) sum_d = sum_d + SumW'(prod_q[i]);
   end

   always_comb begin
      shifted = sum_q >>> bus.shift;
      mag     = (bus.abs_en && shifted[SumW-1]) ? -shifted : shifted;
      if (mag[SumW-1]) begin
         clamped = '0;
      end else if (|mag[SumW-2:WORD_SIZE]) begin
         clamped = '1;
      end else begin
         clamped = mag[WORD_SIZE-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         v1_q        <= window_valid;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         if (v2_q) out_pixel_q <= clamped;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_pixel = out_pixel_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// Randomised self-checking bench for conv2d_stream against a direct correlation model.
module tb_conv2d_stream;
   localparam int RS = 8;
   localparam int K  = 3;
   localparam int WS = 8;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv2d_stream_if #(.WORD_SIZE(WS), .KERNEL_DIM(K), .COEF_WIDTH(CW)) bus ();

   conv2d_stream #(
      .WORD_SIZE  (WS),
      .ROW_SIZE   (RS),
      .KERNEL_DIM (K),
      .COEF_WIDTH (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int img [8][8];
   int mcoef [9];
   int mshift;
   bit mabs;
   int exp_px[$], exp_cyc[$], obs_px[$], obs_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         obs_px.push_back(int'(bus.out_pixel));
         obs_cyc.push_back(cyc);
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Direct correlation over the window whose newest pixel is (y,x).
   function automatic int ref_px(input int y, input int x);
      int s = 0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            s += img[y-K+1+r][x-K+1+c] * mcoef[r*K+c];
      s = s >>> mshift;
      if (mabs && s < 0) s = -s;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      return s;
   endfunction

   task automatic clear_queues();
      exp_px.delete(); exp_cyc.delete(); obs_px.delete(); obs_cyc.delete();
   endtask

   task automatic set_cfg();
      bus.shift  = 4'(mshift);
      bus.abs_en = mabs;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.coef_we = 1'b0;
      @(negedge clk);
      clear_queues();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) mcoef[i] = (i == 4) ? 8 : -1;
   endtask

   task automatic load_coefs();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.coef_we = 1'b1; bus.coef_addr = 4'(i); bus.coef_data = 8'(mcoef[i]);
      end
      @(negedge clk);
      bus.coef_we = 1'b0;
   endtask

   // Streams rows 0..h-1 of img with a pct% chance of in_valid per cycle.
   task automatic drive_frame(input int h, input int pct, input bit drain);
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < RS; x++) begin
            bit v = 1'b0;
            while (!v) begin
               @(negedge clk);
               v = ($urandom_range(99) < pct);
               bus.in_valid = v;
               bus.in_sof   = v && (y == 0) && (x == 0);
               bus.in_pixel = v ? 8'(img[y][x]) : 8'($urandom);
               if (v && y >= K - 1 && x >= K - 1) begin
                  exp_px.push_back(ref_px(y, x));
                  exp_cyc.push_back(cyc + 1 + 3);
               end
            end
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_sof = 1'b0;
      if (drain) repeat (6) @(negedge clk);
   endtask

   task automatic fill(input int mode, input int val);
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            img[y][x] = (mode == 0) ? val : (mode == 1) ? y * 8 + x : int'($urandom_range(255));
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_pixel !== 8'd0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b pixel=%0d want valid=0 pixel=0",
                  bus.out_valid, bus.out_pixel);
      end
   endtask

   task automatic test_constant();
      mshift = 0; mabs = 0; set_cfg();
      fill(0, 10);
      drive_frame(8, 100, 1);
      checks++;
      if (obs_px.size() !== 36) begin
         failures++;
         $display("FAIL const_count got=%0d want=36", obs_px.size());
      end
      for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
         checks++;
         if (obs_px[i] !== exp_px[i] || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL const_px[%0d] got=%0d@%0d want=%0d@%0d",
                     i, obs_px[i], obs_cyc[i], exp_px[i], exp_cyc[i]);
         end
      end
      clear_queues();
   endtask

   task automatic test_single_pixel();
      for (int a = 0; a < 2; a++) begin
         mshift = 0; mabs = bit'(a); set_cfg();
         fill(0, 0);
         img[3][3] = 100;
         drive_frame(8, 100, 1);
         checks++;
         if (obs_px.size() !== exp_px.size()) begin
            failures++;
            $display("FAIL single_count abs=%0d got=%0d want=%0d", a, obs_px.size(), exp_px.size());
         end
         if (obs_px.size() > 14) begin
            checks += 2;
            if (obs_px[14] !== 255) begin
               failures++;
               $display("FAIL single_centre abs=%0d got=%0d want=255", a, obs_px[14]);
            end
            if (obs_px[13] !== (a ? 100 : 0)) begin
               failures++;
               $display("FAIL single_neigh abs=%0d got=%0d want=%0d", a, obs_px[13], a ? 100 : 0);
            end
         end
         for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
            checks++;
            if (obs_px[i] !== exp_px[i] || obs_cyc[i] !== exp_cyc[i]) begin
               failures++;
               $display("FAIL single_px[%0d] got=%0d@%0d want=%0d@%0d",
                        i, obs_px[i], obs_cyc[i], exp_px[i], exp_cyc[i]);
            end
         end
         clear_queues();
      end
   endtask

   task automatic test_identity();
      for (int i = 0; i < 9; i++) mcoef[i] = (i == 4) ? 1 : 0;
      load_coefs();
      mshift = 0; mabs = 0; set_cfg();
      fill(1, 0);
      drive_frame(8, 100, 1);
      checks++;
      if (obs_px.size() !== 36 || obs_px[0] !== 9 || obs_px[6] !== 17) begin
         failures++;
         $display("FAIL ident_shape got count=%0d first=%0d seventh=%0d want 36,9,17",
                  obs_px.size(), obs_px.size() > 0 ? obs_px[0] : -1,
                  obs_px.size() > 6 ? obs_px[6] : -1);
      end
      for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
         checks++;
         if (obs_px[i] !== exp_px[i] || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL ident_px[%0d] got=%0d@%0d want=%0d@%0d",
                     i, obs_px[i], obs_cyc[i], exp_px[i], exp_cyc[i]);
         end
      end
      clear_queues();
   endtask

   task automatic test_stall();
      fill(1, 0);
      drive_frame(8, 50, 1);
      checks++;
      if (obs_px.size() !== 36) begin
         failures++;
         $display("FAIL stall_count got=%0d want=36", obs_px.size());
      end
      for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
         checks++;
         if (obs_px[i] !== exp_px[i] || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL stall_px[%0d] got=%0d@%0d want=%0d@%0d",
                     i, obs_px[i], obs_cyc[i], exp_px[i], exp_cyc[i]);
         end
      end
      clear_queues();
   endtask

   task automatic test_box_shift();
      for (int i = 0; i < 9; i++) mcoef[i] = 1;
      load_coefs();
      mshift = 3; mabs = 0; set_cfg();
      fill(0, 80);
      drive_frame(8, 100, 1);
      checks++;
      if (obs_px.size() !== 36 || obs_px[35] !== 90) begin
         failures++;
         $display("FAIL box_shape got count=%0d last=%0d want 36,90",
                  obs_px.size(), obs_px.size() > 35 ? obs_px[35] : -1);
      end
      for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
         checks++;
         if (obs_px[i] !== exp_px[i] || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL box_px[%0d] got=%0d@%0d want=%0d@%0d",
                     i, obs_px[i], obs_cyc[i], exp_px[i], exp_cyc[i]);
         end
      end
      clear_queues();
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 9; i++) mcoef[i] = int'($urandom_range(255)) - 128;
         load_coefs();
         mshift = int'($urandom_range(15)); mabs = bit'($urandom_range(1)); set_cfg();
         fill(2, 0);
         drive_frame(8, int'($urandom_range(100, 40)), 1);
         checks++;
         if (obs_px.size() !== 36) begin
            failures++;
            $display("FAIL rand%0d_count got=%0d want=36", n, obs_px.size());
         end
         for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
            checks++;
            if (obs_px[i] !== exp_px[i] || obs_cyc[i] !== exp_cyc[i]) begin
               failures++;
               $display("FAIL rand%0d_px[%0d] got=%0d@%0d want=%0d@%0d",
                        n, i, obs_px[i], obs_cyc[i], exp_px[i], exp_cyc[i]);
            end
         end
         clear_queues();
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 9; i++) mcoef[i] = (i == 4) ? 1 : 0;
      load_coefs();
      fill(2, 0);
      drive_frame(5, 100, 0);
      apply_reset();
      mshift = 0; mabs = 0; set_cfg();
      repeat (6) @(negedge clk);
      checks++;
      if (obs_px.size() !== 0) begin
         failures++;
         $display("FAIL rst_mid_stale got=%0d pulses want=0", obs_px.size());
      end
      clear_queues();
      fill(2, 0);
      drive_frame(8, 100, 1);
      checks++;
      if (obs_px.size() !== 36) begin
         failures++;
         $display("FAIL rst_mid_count got=%0d want=36", obs_px.size());
      end
      for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
         checks++;
         if (obs_px[i] !== exp_px[i] || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL rst_mid_px[%0d] got=%0d@%0d want=%0d@%0d",
                     i, obs_px[i], obs_cyc[i], exp_px[i], exp_cyc[i]);
         end
      end
      clear_queues();
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_pixel = '0;
      bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
      bus.shift = '0; bus.abs_en = 1'b0;
      mshift = 0; mabs = 0;
      test_reset();
      test_constant();
      test_single_pixel();
      test_identity();
      test_stall();
      test_box_shift();
      test_random();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
